// File: rtl/alu_dispatch_24bit.sv
// Sequential ALU dispatcher: single-cycle ops plus a 24-step shift-add multiply,
// with valid/ready request and response handshakes and a one-hot unit enable.
module alu_dispatch_24bit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [23:0] req_a,
  input  logic [23:0] req_b,
  output logic [2:0]  unit_sel,
  output logic [7:0]  unit_en,
  output logic        busy,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [23:0] resp_data,
  output logic        resp_err
);

  localparam int unsigned W      = 24;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned UNITS  = 8;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SLT = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         unit_sel_q, unit_sel_d;
  logic [UNITS-1:0]   unit_en_q, unit_en_d;
  logic               req_ready_q, req_ready_d;
  logic               busy_q, busy_d;
  logic               resp_valid_q, resp_valid_d;
  logic [W-1:0]       resp_data_q, resp_data_d;
  logic               resp_err_q, resp_err_d;
  logic [W-1:0]       alu_res;
  logic [W-1:0]       mul_sum;

  // Single-cycle result, computed straight from the request operands.
  always_comb begin
    alu_res = '0;
    unique case (req_op)
      OP_AND:  alu_res = req_a & req_b;
      OP_OR:   alu_res = req_a | req_b;
      OP_ADD:  alu_res = req_a + req_b;
      OP_SLT:  alu_res = W'($signed(req_a) < $signed(req_b));
      OP_XOR:  alu_res = req_a ^ req_b;
      OP_SLL:  alu_res = (req_b[SHAMT_W-1:0] >= SHAMT_W'(W)) ? '0 : (req_a << req_b[SHAMT_W-1:0]);
      default: alu_res = '0;
    endcase
  end

  assign mul_sum = acc_q + (b_q[0] ? a_q : '0);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    unit_sel_d  = unit_sel_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          unit_sel_d = req_op;
          if (req_op == OP_MUL) begin
            a_d     = req_a;
            b_d     = req_b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_MUL;
          end else begin
            resp_data_d = alu_res;
            resp_err_d  = (req_op == OP_ILL);
            state_d     = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        // Final iteration publishes the sum including this step's add.
        if (cnt_q == CNT_W'(W - 1)) begin
          resp_data_d = mul_sum;
          resp_err_d  = 1'b0;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_ready) begin
          resp_err_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state.
    req_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    resp_valid_d = (state_d == S_DONE);
    unit_en_d    = (state_d != S_IDLE) ? (UNITS'(1) << unit_sel_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      unit_sel_q   <= '0;
      unit_en_q    <= '0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      unit_sel_q   <= unit_sel_d;
      unit_en_q    <= unit_en_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign unit_sel   = unit_sel_q;
  assign unit_en    = unit_en_q;

endmodule

// File: tb/tb_alu_dispatch_24bit.sv
// Directed bench for alu_dispatch_24bit; expected responses go through a
// scoreboard queue popped by a monitor on each response handshake.
module tb_alu_dispatch_24bit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [23:0] req_a;
  logic [23:0] req_b;
  logic [2:0]  unit_sel;
  logic [7:0]  unit_en;
  logic        busy;
  logic        resp_valid;
  logic        resp_ready;
  logic [23:0] resp_data;
  logic        resp_err;

  int tests = 0;
  int fails = 0;
  logic [24:0] exp_q[$];

  alu_dispatch_24bit dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .unit_sel  (unit_sel),
    .unit_en   (unit_en),
    .busy      (busy),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (reset === 1'b0 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'(resp_data), 32'hDEAD_BEEF);
      end else begin
        logic [24:0] e;
        e = exp_q.pop_front();
        chk("resp_data", 32'(resp_data), 32'(e[23:0]));
        chk("resp_err", 32'(resp_err), 32'(e[24]));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [23:0] a, input logic [23:0] b,
                       input logic [23:0] exp, input logic err);
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) chk("accept_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    exp_q.push_back({err, exp});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Called just after the acceptance edge; counts edges until resp_valid.
  task automatic wait_resp(input logic [2:0] op, input int exp_lat);
    int lat = 0;
    logic ok_busy = 1'b1;
    while (resp_valid !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1 || req_ready !== 1'b0) ok_busy = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_before_done", 32'(ok_busy), 32'd1);
    chk("unit_en", 32'(unit_en), 32'(8'(1) << op));
    chk("unit_sel", 32'(unit_sel), 32'(op));
    chk("busy_done", 32'(busy), 32'd1);
    chk("req_ready_done", 32'(req_ready), 32'd0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [23:0] a, input logic [23:0] b,
                        input logic [23:0] exp, input logic err, input int exp_lat);
    issue(op, a, b, exp, err);
    wait_resp(op, exp_lat);
    @(posedge clk);
    #1;
    chk("req_ready_after_hs", 32'(req_ready), 32'd1);
    chk("resp_valid_after_hs", 32'(resp_valid), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_resp_data"}, 32'(resp_data), 32'd0);
    chk({tag, "_unit_sel"}, 32'(unit_sel), 32'd0);
    chk({tag, "_unit_en"}, 32'(unit_en), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_valid;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;

    // Single-cycle operations, consumer always ready.
    run_op(3'd2, 24'hFFFFFF, 24'h000002, 24'h000001, 1'b0, 0);
    run_op(3'd0, 24'hF0F0F0, 24'h3C3C3C, 24'h303030, 1'b0, 0);
    run_op(3'd3, 24'h800000, 24'h000001, 24'h000001, 1'b0, 0);
    run_op(3'd3, 24'h000001, 24'h800000, 24'h000000, 1'b0, 0);
    run_op(3'd6, 24'h000001, 24'h000018, 24'h000000, 1'b0, 0);
    run_op(3'd6, 24'h000001, 24'h00001F, 24'h000000, 1'b0, 0);
    run_op(3'd6, 24'h000001, 24'h000017, 24'h800000, 1'b0, 0);
    run_op(3'd6, 24'h000003, 24'hFFFFE4, 24'h000030, 1'b0, 0);

    // Multiply.
    run_op(3'd4, 24'h001234, 24'h000100, 24'h123400, 1'b0, 24);
    run_op(3'd4, 24'hFFFFFF, 24'hFFFFFF, 24'h000001, 1'b0, 24);
    run_op(3'd4, 24'h000007, 24'h000006, 24'h00002A, 1'b0, 24);

    // Illegal opcode.
    run_op(3'd7, 24'h123456, 24'h654321, 24'h000000, 1'b1, 0);

    // Backpressure: XOR held for 10 cycles while a new request waits.
    resp_ready = 1'b0;
    issue(3'd5, 24'hAAAAAA, 24'hFFFFFF, 24'h555555, 1'b0);
    wait_resp(3'd5, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = 3'd2;
      req_a     = 24'h000001;
      req_b     = 24'h000002;
      chk("bp_resp_data", 32'(resp_data), 32'h555555);
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    exp_q.push_back({1'b0, 24'h000003});
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_req_ready_after_hs", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("bp_accept_next_edge", 32'(resp_valid), 32'd1);
    chk("bp_req_ready_busy", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;

    // Reset on the 10th multiply iteration abandons the request.
    issue(3'd4, 24'h001234, 24'h000100, 24'h123400, 1'b0);
    void'(exp_q.pop_back());
    repeat (9) @(posedge clk);
    #1;
    chk("mid_mul_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("mul_reset");
    reset = 1'b0;
    saw_valid = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (resp_valid !== 1'b0) saw_valid = 1'b1;
    end
    chk("no_resp_after_reset", 32'(saw_valid), 32'd0);

    run_op(3'd1, 24'h0F0F0F, 24'hF00000, 24'hFF0F0F, 1'b0, 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
